// File: rtl/hazard_unit.sv
// RAW hazard detection over an EXE/MEM/WB write-tracking slot pipeline, with stall counter.
// Build option: define FORWARDING_EN for load-use-only stalls and live EXE forward selects.
module hazard_unit #(
    parameter int REG_ADDR_LEN  = 5,
    parameter int STALL_CNT_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_LEN-1:0]  id_src1,
    input  logic [REG_ADDR_LEN-1:0]  id_src2,
    input  logic                     id_two_src,
    input  logic [REG_ADDR_LEN-1:0]  id_dest,
    input  logic                     id_wb_en,
    input  logic                     id_mem_r_en,
    input  logic                     flush,
    output logic                     hazard_detected,
    output logic [1:0]               fwd_sel_a,
    output logic [1:0]               fwd_sel_b,
    output logic [STALL_CNT_LEN-1:0] stall_count
);

    typedef struct packed {
        logic                    wb_en;
        logic                    mem_r_en;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic                    two_src;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_MEM     = 2'b01;
    localparam logic [1:0] SEL_WB      = 2'b10;

    slot_t exe_q, exe_d;
    slot_t mem_q, mem_d;
    slot_t wb_q,  wb_d;
    logic [STALL_CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;

    logic raw;
    logic src1_hit_exe, src2_hit_exe;
    logic src1_hit_mem, src2_hit_mem;

    // Register 0 is hardwired, so a slot targeting it never produces a dependency.
    function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_LEN-1:0] r);
        return s.wb_en && (s.dest == r) && (r != '0);
    endfunction

    function automatic logic [1:0] fwd_select(input slot_t m, input slot_t w,
                                              input logic [REG_ADDR_LEN-1:0] r);
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (slot_writes(m, r)) begin
            sel = SEL_MEM;
        end else if (slot_writes(w, r)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        src1_hit_exe = slot_writes(exe_q, id_src1);
        src2_hit_exe = id_two_src && slot_writes(exe_q, id_src2);
        src1_hit_mem = slot_writes(mem_q, id_src1);
        src2_hit_mem = id_two_src && slot_writes(mem_q, id_src2);
    end

`ifdef FORWARDING_EN
    // Only a load still in EXE cannot be bypassed in time for the next instruction.
    always_comb begin
        raw = exe_q.mem_r_en && (src1_hit_exe || src2_hit_exe);
    end

    always_comb begin
        fwd_sel_a = fwd_select(mem_q, wb_q, exe_q.src1);
        fwd_sel_b = SEL_REGFILE;
        if (exe_q.two_src) begin
            fwd_sel_b = fwd_select(mem_q, wb_q, exe_q.src2);
        end
    end
`else
    // WB is excluded: the register file writes in the first half and reads in the second.
    always_comb begin
        raw = src1_hit_exe || src2_hit_exe || src1_hit_mem || src2_hit_mem;
    end

    always_comb begin
        fwd_sel_a = SEL_REGFILE;
        fwd_sel_b = SEL_REGFILE;
    end
`endif

    always_comb begin
        hazard_detected = raw && !flush;
    end

    // The bubble is forced here rather than taken from squashed controller enables,
    // which would close a loop through hazard_detected.
    always_comb begin
        exe_d = SLOT_BUBBLE;
        if (!(raw || flush)) begin
            exe_d.wb_en    = id_wb_en;
            exe_d.mem_r_en = id_mem_r_en;
            exe_d.dest     = id_dest;
            exe_d.src1     = id_src1;
            exe_d.src2     = id_src2;
            exe_d.two_src  = id_two_src;
        end
        mem_d = exe_q;
        wb_d  = mem_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_detected && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q       <= SLOT_BUBBLE;
            mem_q       <= SLOT_BUBBLE;
            wb_q        <= SLOT_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

    // Not every slot field feeds logic in every build; slots keep a uniform layout.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{exe_q, mem_q, wb_q};

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Generates `hazard_detected` for the decode-stage controller and tracks in-flight register writes across EXE, MEM and WB in an internal slot pipeline.
- Detects read-after-write conflicts for the instruction in ID and inserts bubbles by asserting `hazard_detected`. It then loads its own EXE slot with a bubble.
- Optionally produces operand-forwarding selects for the EXE-stage ALU.
- Counts stall cycles for performance debug.

## Interface
- REG_ADDR_LEN, 5, register-address width
- STALL_CNT_LEN, 16, stall counter width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_src1  in  REG_ADDR_LEN  first source register of ID instruction
- id_src2  in  REG_ADDR_LEN  second source register of ID instruction
- id_two_src  in  1  ID instruction reads id_src2 (register-form ALU, store, BNE)
- id_dest  in  REG_ADDR_LEN  destination register of ID instruction
- id_wb_en  in  1  ID instruction writes register file (controller WB_EN)
- id_mem_r_en  in  1  ID instruction is a load (controller MEM_R_EN)
- flush  in  1  taken branch/jump; ID instruction discarded this cycle
- hazard_detected  out  1  stall PC/IF-ID, squash controller write enables
- fwd_sel_a  out  2  EXE operand A source: 00 regfile, 01 MEM slot, 10 WB slot
- fwd_sel_b  out  2  EXE operand B source, same encoding
- stall_count  out  STALL_CNT_LEN  saturating count of stall cycles

## Operation
- Three slots: EXE, MEM, WB. Each holds {valid-write `wb_en`, `mem_r_en`, `dest`, `src1`, `src2`, `two_src`}.
- A slot "writes r" when `wb_en`=1 and `dest`=r and r≠0. Register 0 never creates a hazard and is never forwarded.
- Source match for ID: src1 always checked; src2 checked only when `id_two_src`=1.
- raw (no forwarding): an ID source matches a writing EXE slot or a writing MEM slot. WB is not checked; the register file writes before it reads.
- raw (forwarding): an ID source matches a writing EXE slot whose `mem_r_en`=1 (load-use).
- hazard_detected = raw & ~flush. Flush masks the stall because the ID instruction is discarded anyway.
- Slot update each rising edge:
  - EXE ← bubble (all zero) if hazard_detected or flush; otherwise ← ID fields.
  - MEM ← EXE.
  - WB ← MEM.
- The EXE bubble is forced internally. It does not rely on the controller's squashed WB_EN, which avoids a combinational loop.
- Forward selects evaluate the EXE slot's registered sources:
  - 01 if MEM writes the source.
  - Else 10 if WB writes the source.
  - Else 00.
  - MEM has priority over WB.
  - Operand B is evaluated only when EXE.two_src=1; otherwise fwd_sel_b is 00.
- stall_count increments by 1 on each edge where hazard_detected=1. It holds at all ones.

## Timing
- hazard_detected: combinational, same cycle as ID inputs. Depends only on ID inputs and registered slots.
- fwd_sel_a/b: combinational from registered slots, valid for the whole EXE cycle.
- Stall length without forwarding:
  - 2 cycles when the producer is immediately ahead.
  - 1 cycle when one independent instruction separates producer and consumer.
- Stall length with forwarding: exactly 1 cycle, and only for a load followed immediately by a consumer.
- Reset (rst=0, asynchronous):
  - All slots cleared.
  - stall_count=0.
  - hazard_detected=0 and fwd_sel_a/b=00 while in reset.
- Reset asserted mid-stall aborts the stall immediately.
- Flush and hazard in the same cycle:
  - hazard_detected=0.
  - EXE gets a bubble.
  - stall_count unchanged.

## Configuration
- FORWARDING_EN defined:
  - Load-use-only stall rule applies.
  - fwd_sel_a/b are driven as above.
- FORWARDING_EN undefined:
  - Full EXE/MEM RAW stall rule applies.
  - fwd_sel_a/b tied to 00.
  - Ports are present in both builds.

## Test plan
- Reset: hold rst=0 with arbitrary ID inputs -> hazard_detected=0, fwd_sel=00, stall_count=0. After release, first cycle with no matches -> hazard_detected=0.
- No FORWARDING_EN: ADD r3 (dest 3, wb_en) then ADD r4←r3,r1 back-to-back -> hazard_detected=1 for 2 cycles, then 0; stall_count=2.
- FORWARDING_EN: same pair -> no stall; fwd_sel_a=01 when the consumer is in EXE. With one instruction between the pair -> fwd_sel_a=10.
- FORWARDING_EN: load r5 then ADD r6←r1,r5 (two_src=1) -> 1-cycle stall, then fwd_sel_b=10 in the consumer's EXE cycle; stall_count=1.
- Non-hazards:
  - Dest r0 producer followed by a consumer of r0 -> no stall.
  - id_two_src=0 with id_src2 matching the EXE dest -> no stall.
- Flush and reset:
  - flush=1 during an active hazard -> hazard_detected=0, EXE bubble, stall_count unchanged.
  - rst=0 mid-stall -> outputs cleared immediately.
  - Saturation: force 2^STALL_CNT_LEN+3 stall cycles -> stall_count holds all ones.
